// File: rtl/memory_game_ctrl.sv
// rtl/memory_game_ctrl.sv - card-matching game controller: shuffle, board writes, pick/compare loop
// Board value/status lives here; every board change is mirrored out through WriteEnable/dataLoc/dataOut.
module memory_game_ctrl #(
  parameter int NUM_PAIRS     = 8,
  parameter int LOC_W         = 4,
  parameter int VAL_W         = 3,
  parameter int REVEAL_CYCLES = 2**24,
  parameter int MAX_MISSES    = 0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Select,
  input  logic [LOC_W-1:0] SelLoc,
  input  logic [LOC_W-1:0] Rand,
  output logic             RandEn,
  output logic             WriteEnable,
  output logic [LOC_W-1:0] dataLoc,
  output logic [VAL_W+1:0] dataOut,
  output logic [3:0]       state,
  output logic [VAL_W:0]   numMatches,
  output logic [7:0]       numMoves,
  output logic             Win,
  output logic             Lose
);
  localparam int N     = 2 * NUM_PAIRS;
  localparam int DEPTH = 2**LOC_W;
  localparam int CNT_W = $clog2(REVEAL_CYCLES + 1);
  localparam logic [1:0] ST_UP = 2'b00, ST_DOWN = 2'b01, ST_REM = 2'b10;

  typedef enum logic [3:0] {
    IDLE = 4'd0, SHUFFLE = 4'd1, WRITE = 4'd2, PICK1 = 4'd3, SHOW1 = 4'd4, PICK2 = 4'd5,
    SHOW2 = 4'd6, HOLD = 4'd7, REMOVE = 4'd8, HIDE = 4'd9, WIN = 4'd10, LOSE = 4'd11
  } state_t;

  state_t           st;
  logic [VAL_W-1:0] bval  [DEPTH];
  logic [1:0]       bstat [DEPTH];
  logic [LOC_W-1:0] idx, loc1, loc2;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       misses;
  logic             sel_q, phase;
  logic             pick_ok;

  assign state   = st;
  assign pick_ok = Select && !sel_q && (int'(SelLoc) < N) && (bstat[SelLoc] == ST_DOWN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st          <= IDLE;
      WriteEnable <= 1'b0;
      dataLoc     <= '0;
      dataOut     <= '0;
      numMatches  <= '0;
      numMoves    <= '0;
      misses      <= '0;
      RandEn      <= 1'b0;
      Win         <= 1'b0;
      Lose        <= 1'b0;
      sel_q       <= 1'b0;
      idx         <= '0;
      loc1        <= '0;
      loc2        <= '0;
      cnt         <= '0;
      phase       <= 1'b0;
    end else begin
      sel_q       <= Select;
      WriteEnable <= 1'b0;
      case (st)
        IDLE: begin
          for (int k = 0; k < DEPTH; k++) begin
            bval[k]  <= VAL_W'(k >> 1);
            bstat[k] <= (k < N) ? ST_DOWN : ST_REM;
          end
          numMatches <= '0;
          numMoves   <= '0;
          misses     <= '0;
          idx        <= LOC_W'(N - 1);
          if (Start) begin
            st     <= SHUFFLE;
            RandEn <= 1'b1;
          end
        end
        SHUFFLE: begin
          // Out-of-range draws are rejected rather than folded, keeping the shuffle unbiased.
          if (Rand <= idx) begin
            bval[idx]  <= bval[Rand];
            bval[Rand] <= bval[idx];
            if (idx == LOC_W'(1)) begin
              st          <= WRITE;
              RandEn      <= 1'b0;
              idx         <= '0;
              WriteEnable <= 1'b1;
              dataLoc     <= '0;
              dataOut     <= {ST_DOWN, (Rand == '0) ? bval[1] : bval[0]};
            end else begin
              idx <= idx - 1'b1;
            end
          end
        end
        WRITE: begin
          if (int'(idx) == N - 1) begin
            st <= PICK1;
          end else begin
            idx         <= idx + 1'b1;
            WriteEnable <= 1'b1;
            dataLoc     <= idx + 1'b1;
            dataOut     <= {ST_DOWN, bval[idx + 1'b1]};
          end
        end
        PICK1, PICK2: begin
          if (pick_ok) begin
            if (st == PICK1) loc1 <= SelLoc;
            else             loc2 <= SelLoc;
            bstat[SelLoc] <= ST_UP;
            WriteEnable   <= 1'b1;
            dataLoc       <= SelLoc;
            dataOut       <= {ST_UP, bval[SelLoc]};
            st            <= (st == PICK1) ? SHOW1 : SHOW2;
          end
        end
        SHOW1: st <= PICK2;
        SHOW2: begin
          cnt <= '0;
          st  <= HOLD;
        end
        HOLD: begin
          if (cnt == CNT_W'(REVEAL_CYCLES - 1)) begin
            if (numMoves != 8'hFF) numMoves <= numMoves + 1'b1;
            phase       <= 1'b0;
            WriteEnable <= 1'b1;
            dataLoc     <= loc1;
            if (bval[loc1] == bval[loc2]) begin
              st          <= REMOVE;
              bstat[loc1] <= ST_REM;
              dataOut     <= {ST_REM, bval[loc1]};
            end else begin
              st          <= HIDE;
              bstat[loc1] <= ST_DOWN;
              dataOut     <= {ST_DOWN, bval[loc1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REMOVE, HIDE: begin
          // First cycle drives loc1 (set up in HOLD) and queues loc2; second cycle resolves.
          if (!phase) begin
            phase       <= 1'b1;
            WriteEnable <= 1'b1;
            dataLoc     <= loc2;
            bstat[loc2] <= (st == REMOVE) ? ST_REM : ST_DOWN;
            dataOut     <= {(st == REMOVE) ? ST_REM : ST_DOWN, bval[loc2]};
          end else if (st == REMOVE) begin
            numMatches <= numMatches + 1'b1;
            if (int'(numMatches) + 1 == NUM_PAIRS) begin
              st  <= WIN;
              Win <= 1'b1;
            end else begin
              st <= PICK1;
            end
          end else begin
            misses <= misses + 1'b1;
            if (MAX_MISSES != 0 && int'(misses) + 1 == MAX_MISSES) begin
              st   <= LOSE;
              Lose <= 1'b1;
            end else begin
              st <= PICK1;
            end
          end
        end
        WIN, LOSE: begin
          if (Ack) begin
            st         <= IDLE;
            Win        <= 1'b0;
            Lose       <= 1'b0;
            numMatches <= '0;
            numMoves   <= '0;
            misses     <= '0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Parametrised next-generation gameplay controller for the card-matching game.
- Owns the board state internally: card value plus status per location. It shuffles the board with an unbiased swap shuffle driven by the external LFSR, streams board writes to the display/board RAM, and runs the pick/compare/reveal loop.
- Adds configurable pair count, configurable reveal time, rejection of illegal picks, and a move counter.
- Adds an optional miss-limit LOSE mode.

Parameters:
- NUM_PAIRS, 8: number of card pairs; N = 2*NUM_PAIRS locations; 2..8.
- LOC_W, 4: location width; 2**LOC_W >= N.
- VAL_W, 3: card-value width; 2**VAL_W >= NUM_PAIRS.
- REVEAL_CYCLES, 2**24: cycles both picked cards stay face-up before compare resolves; >= 1.
- MAX_MISSES, 0: mismatches allowed before LOSE; 0 = unlimited, LOSE unreachable.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  begin a game from IDLE.
- Ack  in  1  leave WIN/LOSE.
- Select  in  1  pick strobe; rising edge only.
- SelLoc  in  LOC_W  location being picked.
- Rand  in  LOC_W  random value from the LFSR.
- RandEn  out  1  LFSR advance enable.
- WriteEnable  out  1  dataLoc/dataOut valid this cycle.
- dataLoc  out  LOC_W  board location being written.
- dataOut  out  2+VAL_W  {status[1:0], value}; status 00 = face-up, 01 = face-down, 10 = removed.
- state  out  4  encoded FSM state.
- numMatches  out  VAL_W+1  pairs matched.
- numMoves  out  8  completed pick pairs; saturates at 255.
- Win  out  1  high in WIN.
- Lose  out  1  high in LOSE.

Behaviour:
- Reset values (on Clk edge with Reset=1):
  - state = IDLE (0), WriteEnable = 0, dataLoc = 0, dataOut = 0.
  - numMatches = 0, numMoves = 0, misses = 0, RandEn = 0, Win = 0, Lose = 0.
  - Select edge register = 0.
  - Reset overrides every state mid-game; board contents are don't-care after reset.
- Outputs are registered. WriteEnable is high only in the cycles listed below.
- State encodings: IDLE=0, SHUFFLE=1, WRITE=2, PICK1=3, SHOW1=4, PICK2=5, SHOW2=6, HOLD=7, REMOVE=8, HIDE=9, WIN=10, LOSE=11; other codes -> IDLE.
- IDLE:
  - Each cycle, load board[k] = {face-down, k>>1} for k = 0..N-1.
  - Clear all counters; set index i = N-1.
  - Start=1 -> SHUFFLE.
- SHUFFLE:
  - RandEn = 1.
  - Each cycle: if Rand <= i, swap values of board[i] and board[Rand] and decrement i; otherwise reject and retry next cycle.
  - Swap with i==1 done -> WRITE, with k = 0.
- WRITE:
  - One location per cycle: WriteEnable=1, dataLoc=k, dataOut={01, board[k].value}.
  - After k = N-1 -> PICK1. Exactly N write cycles.
- PICK1 / PICK2 pick rules:
  - A pick is a Select rising edge (Select=1, previous Select=0) with SelLoc < N and board[SelLoc] face-down.
  - Any other edge, or a held level, is ignored. Picks are never queued.
  - Edges in any other state are dropped.
- PICK1: valid pick -> latch loc1, mark loc1 face-up, go to SHOW1.
- SHOW1: one cycle, WriteEnable=1, dataLoc=loc1, dataOut={00, value}; -> PICK2.
- PICK2: valid pick -> latch loc2, mark face-up. loc1 is already face-up, so it is rejected. -> SHOW2.
- SHOW2: one write cycle of loc2 (face-up); -> HOLD with counter = 0.
- HOLD:
  - Count cycles; at counter == REVEAL_CYCLES-1, increment numMoves (saturating at 255).
  - Values equal -> REMOVE; otherwise -> HIDE.
  - Select is ignored in HOLD.
- REMOVE:
  - Two write cycles: loc1 then loc2, status 10; board updated to removed.
  - numMatches++ in the second cycle. If the new value == NUM_PAIRS -> WIN, else -> PICK1.
- HIDE:
  - Two write cycles: loc1 then loc2, status 01; board reverts to face-down.
  - misses++. If MAX_MISSES != 0 and misses == MAX_MISSES -> LOSE, else -> PICK1.
- WIN / LOSE: Win (or Lose) = 1; Ack=1 -> IDLE. Ack is ignored elsewhere; Start is ignored outside IDLE.

Test Plan:
- NUM_PAIRS=2, Reset, then Start with Rand stuck at 3 -> RandEn high.
  - Board shuffles: i=3 swaps with 3, Rand=3 is rejected at i=2 until Rand changes.
  - Rand=0 -> WRITE issues exactly 4 WriteEnable cycles, dataLoc 0..3, status 01.
- REVEAL_CYCLES=4, pick the two locations holding value 1 -> SHOW1/SHOW2 writes with status 00.
  - HOLD lasts 4 cycles; REMOVE writes status 10 to loc1 then loc2.
  - numMatches=1, numMoves=1, back in PICK1.
- Mismatching picks -> HIDE writes status 01 to both locations; numMatches unchanged, numMoves+1.
  - With MAX_MISSES=1: LOSE, Lose=1; Ack -> IDLE with counters cleared.
- Invalid picks produce no write and no state change:
  - same location picked twice;
  - SelLoc=5 with N=4;
  - a removed card;
  - Select held high across PICK1;
  - Select pulse during HOLD.
- Match all NUM_PAIRS=2 pairs -> WIN, Win=1. Ack=0 holds WIN; Ack=1 -> IDLE.
- Reset asserted during HOLD and during WRITE -> next cycle state=0, WriteEnable=0, counters 0. A fresh Start replays the full shuffle.
